// File: rtl/mod_halver_iter.sv
// Iterative modular halver: computes x * 2^-K mod Q, one halving step per clock.
// Odd accumulators take the (acc + Q) >> 1 path, so the result stays below Q without a final subtraction.
module mod_halver_iter #(
    parameter int unsigned BITWIDTH = 16,
    parameter int unsigned KWIDTH   = 5
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iClr,
    input  logic                iStart,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iQ,
    input  logic [KWIDTH-1:0]   iK,
    output logic [BITWIDTH-1:0] oData,
    output logic                oBusy,
    output logic                oDone
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e              state;
    logic [BITWIDTH-1:0] acc;
    logic [BITWIDTH-1:0] qReg;
    logic [KWIDTH-1:0]   cnt;
    logic [BITWIDTH:0]   sum;
    logic [BITWIDTH-1:0] halfAcc;

    // Carry bit kept so that acc + Q never wraps for legal operands.
    always_comb begin
        sum     = {1'b0, acc};
        if (acc[0]) begin
            sum = {1'b0, acc} + {1'b0, qReg};
        end
        halfAcc = BITWIDTH'(sum >> 1);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= StIdle;
            acc   <= '0;
            qReg  <= '0;
            cnt   <= '0;
            oData <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else if (iClr) begin
            state <= StIdle;
            acc   <= '0;
            qReg  <= '0;
            cnt   <= '0;
            oData <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        acc   <= iData;
                        qReg  <= iQ;
                        cnt   <= iK;
                        oBusy <= 1'b1;
                        if (iK == '0) begin
                            state <= StDone;
                            oData <= iData;
                            oDone <= 1'b1;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    acc <= halfAcc;
                    cnt <= cnt - 1'b1;
                    if (cnt == KWIDTH'(1)) begin
                        state <= StDone;
                        oData <= halfAcc;
                        oDone <= 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    oBusy <= 1'b0;
                    oDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_halver_iter.sv
// Bench for mod_halver_iter: directed vector table, multi-cycle corner sequences, and a randomized
// regression compared against a multiplicative-inverse reference.
module tb_mod_halver_iter;

    localparam int unsigned BITWIDTH = 16;
    localparam int unsigned KWIDTH   = 5;

    logic                iClk;
    logic                iRstN;
    logic                iClr;
    logic                iStart;
    logic [BITWIDTH-1:0] iData;
    logic [BITWIDTH-1:0] iQ;
    logic [KWIDTH-1:0]   iK;
    logic [BITWIDTH-1:0] oData;
    logic                oBusy;
    logic                oDone;

    int checks = 0;
    int errors = 0;
    logic [BITWIDTH-1:0] prevData;

    mod_halver_iter #(
        .BITWIDTH(BITWIDTH),
        .KWIDTH  (KWIDTH)
    ) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iClr  (iClr),
        .iStart(iStart),
        .iData (iData),
        .iQ    (iQ),
        .iK    (iK),
        .oData (oData),
        .oBusy (oBusy),
        .oDone (oDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct {
        logic [BITWIDTH-1:0] x;
        logic [BITWIDTH-1:0] q;
        logic [KWIDTH-1:0]   k;
        logic [BITWIDTH-1:0] expRes;
    } vec_t;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // y * 2^K == x (mod Q), so y = x * ((Q+1)/2)^K mod Q.
    function automatic logic [BITWIDTH-1:0] refHalve(input longint unsigned x,
                                                      input longint unsigned q,
                                                      input int unsigned k);
        longint unsigned y;
        longint unsigned inv2;
        y    = x % q;
        inv2 = (q + 1) / 2;
        for (int i = 0; i < int'(k); i++) y = (y * inv2) % q;
        return BITWIDTH'(y);
    endfunction

    // Called just after a rising edge; returns just after the edge that follows the oDone cycle.
    task automatic runOp(input logic [BITWIDTH-1:0] x, input logic [BITWIDTH-1:0] q,
                         input logic [KWIDTH-1:0] k, input logic [BITWIDTH-1:0] expRes,
                         input string tag);
        int n;
        iStart = 1'b1;
        iData  = x;
        iQ     = q;
        iK     = k;
        @(posedge iClk);
        #1;
        // Junk on the inputs must not disturb the accepted operation.
        iStart = 1'($urandom);
        iData  = BITWIDTH'($urandom);
        iQ     = BITWIDTH'($urandom);
        iK     = KWIDTH'($urandom);
        chk({tag, " busy"}, oBusy, 1);
        if (k != 0) chk({tag, " hold"}, oData, prevData);
        n = 0;
        while (!oDone && n < 40) begin
            @(posedge iClk);
            #1;
            n++;
        end
        chk({tag, " latency"}, n, k);
        chk({tag, " data"}, oData, expRes);
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        chk({tag, " done1cyc"}, oDone, 0);
        chk({tag, " idle"}, oBusy, 0);
        prevData = oData;
    endtask

    vec_t vecs[6];

    initial begin
        logic [BITWIDTH-1:0] rx;
        logic [BITWIDTH-1:0] rq;
        logic [KWIDTH-1:0]   rk;
        logic [BITWIDTH-1:0] exp;
        int doneCount;

        vecs[0] = '{x: 16'd5,     q: 16'd97,    k: 5'd1, expRes: 16'd51};
        vecs[1] = '{x: 16'd5,     q: 16'd97,    k: 5'd3, expRes: 16'd37};
        vecs[2] = '{x: 16'd42,    q: 16'd97,    k: 5'd0, expRes: 16'd42};
        vecs[3] = '{x: 16'd65519, q: 16'd65521, k: 5'd1, expRes: 16'd65520};
        vecs[4] = '{x: 16'd0,     q: 16'd97,    k: 5'd5, expRes: 16'd0};
        vecs[5] = '{x: 16'd96,    q: 16'd97,    k: 5'd1, expRes: 16'd48};

        iRstN  = 1'b0;
        iClr   = 1'b0;
        iStart = 1'b0;
        iData  = '0;
        iQ     = '0;
        iK     = '0;
        prevData = '0;
        repeat (3) @(posedge iClk);
        #1;
        chk("reset data", oData, 0);
        chk("reset busy", oBusy, 0);
        chk("reset done", oDone, 0);
        iRstN = 1'b1;
        @(posedge iClk);
        #1;

        for (int i = 0; i < 6; i++) begin
            runOp(vecs[i].x, vecs[i].q, vecs[i].k, vecs[i].expRes, $sformatf("vec%0d", i));
        end

        // Restart mid-run is ignored, then clear aborts with no completion.
        runOp(16'd5, 16'd97, 5'd1, 16'd51, "preclr");
        iStart = 1'b1; iData = 16'd5; iQ = 16'd97; iK = 5'd4;
        @(posedge iClk); #1;
        iStart = 1'b0;
        @(posedge iClk); #1;
        iStart = 1'b1; iData = 16'd7;
        @(posedge iClk); #1;
        iStart = 1'b0; iClr = 1'b1;
        chk("restart ignored busy", oBusy, 1);
        @(posedge iClk); #1;
        iClr = 1'b0;
        chk("clr data", oData, 0);
        chk("clr busy", oBusy, 0);
        chk("clr done", oDone, 0);
        doneCount = 0;
        repeat (8) begin
            @(posedge iClk); #1;
            if (oDone) doneCount++;
        end
        chk("clr no done", doneCount, 0);
        prevData = '0;

        // Asynchronous reset mid-run.
        runOp(16'd5, 16'd97, 5'd3, 16'd37, "prerst");
        iStart = 1'b1; iData = 16'd11; iQ = 16'd97; iK = 5'd10;
        @(posedge iClk); #1;
        iStart = 1'b0;
        repeat (3) @(posedge iClk);
        #3;
        iRstN = 1'b0;
        #1;
        chk("async rst data", oData, 0);
        chk("async rst busy", oBusy, 0);
        @(negedge iClk);
        iRstN = 1'b1;
        doneCount = 0;
        repeat (15) begin
            @(posedge iClk); #1;
            if (oDone) doneCount++;
        end
        chk("rst no done", doneCount, 0);
        prevData = '0;
        runOp(16'd5, 16'd97, 5'd3, 16'd37, "postrst");

        // Randomized legal regression, issued back to back.
        for (int i = 0; i < 200; i++) begin
            rq  = BITWIDTH'($urandom_range(65535, 3)) | 16'd1;
            rx  = BITWIDTH'($urandom_range(int'(rq) - 1, 0));
            rk  = KWIDTH'($urandom);
            exp = refHalve(rx, rq, rk);
            runOp(rx, rq, rk, exp, $sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d inverse", i), (longint'(oData) << rk) % rq, rx);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
